// File: rtl/pio_pkg.sv
// Shared constants for the Avalon-MM GPIO PIO: register addresses, edge
// selection codes and the arm-counter limit helper.
package pio_pkg;

   localparam logic [2:0] ADDR_DATA     = 3'd0;
   localparam logic [2:0] ADDR_OUT      = 3'd1;
   localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
   localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
   localparam logic [2:0] ADDR_OUTSET   = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR   = 3'd5;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   localparam int ARM_W = 2;

   // Cycles after reset before captures are allowed: long enough for the
   // input pipeline (synchroniser plus delay flop) to hold real samples.
   function automatic logic [ARM_W-1:0] arm_max_f(input logic sync_en);
      return sync_en ? 2'd3 : 2'd1;
   endfunction

endpackage

// File: rtl/pio_edge_detect.sv
// Input conditioning for the GPIO PIO: optional 2-flop synchroniser
// (enabled by defining PIO_IN_SYNC_EN), one-cycle delay register, arm
// counter and edge-pulse generation for the selected edge type.
module pio_edge_detect
   import pio_pkg::*;
#(
   parameter int WIDTH     = 14,
   parameter int EDGE_TYPE = EDGE_RISE
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_port_i,
   output logic [WIDTH-1:0] in_s_o,
   output logic [WIDTH-1:0] edge_o
);

`ifdef PIO_IN_SYNC_EN
   localparam logic [ARM_W-1:0] ARM_MAX = arm_max_f(1'b1);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // Two-flop synchroniser for inputs asynchronous to clk
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= in_port_i;
         sync_q <= meta_q;
      end
   end

   assign in_s_o = sync_q;
`else
   localparam logic [ARM_W-1:0] ARM_MAX = arm_max_f(1'b0);

   assign in_s_o = in_port_i;
`endif

   logic [WIDTH-1:0] in_d_q;
   logic [ARM_W-1:0] arm_cnt_q;
   logic [ARM_W-1:0] arm_cnt_d;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] sel;

   // Delay register for edge comparison and saturating arm counter
   always_ff @(posedge clk) begin
      if (reset) begin
         in_d_q    <= '0;
         arm_cnt_q <= '0;
      end else begin
         in_d_q    <= in_s_o;
         arm_cnt_q <= arm_cnt_d;
      end
   end

   // Arm counter climbs to ARM_MAX once and then holds
   always_comb begin
      arm_cnt_d = arm_cnt_q;
      if (arm_cnt_q != ARM_MAX) begin
         arm_cnt_d = arm_cnt_q + 1'b1;
      end
   end

   // Edge selection; pulses are suppressed until the pipeline is armed
   always_comb begin
      rise = in_s_o & ~in_d_q;
      fall = ~in_s_o & in_d_q;
      case (EDGE_TYPE)
         EDGE_RISE: sel = rise;
         EDGE_FALL: sel = fall;
         default:   sel = rise | fall;
      endcase
      edge_o = (arm_cnt_q == ARM_MAX) ? sel : '0;
   end

endmodule

// File: rtl/avalon_gpio_pio.sv
// Avalon-MM GPIO slave: output register with atomic set/clear, sampled
// input port with edge capture (W1C), per-bit IRQ mask and level IRQ.
// Optional input synchroniser: define PIO_IN_SYNC_EN.
module avalon_gpio_pio
   import pio_pkg::*;
#(
   parameter int               WIDTH       = 14,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               EDGE_TYPE   = EDGE_RISE
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic             irq
);

   logic             wr;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] in_s;
   logic [WIDTH-1:0] edge_pulse;
   logic [WIDTH-1:0] rd_w;
   logic [WIDTH-1:0] cap_clr;
   logic             unused_wd;

   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
   logic [WIDTH-1:0] edge_cap_q, edge_cap_d;

   assign wr        = chipselect & ~write_n;
   assign wd        = writedata[WIDTH-1:0];
   assign unused_wd = ^writedata;

   pio_edge_detect #(
      .WIDTH     (WIDTH),
      .EDGE_TYPE (EDGE_TYPE)
   ) u_edge (
      .clk       (clk),
      .reset     (reset),
      .in_port_i (in_port),
      .in_s_o    (in_s),
      .edge_o    (edge_pulse)
   );

   // Register write decode; a new edge beats a same-cycle W1C clear
   always_comb begin
      data_out_d = data_out_q;
      irq_mask_d = irq_mask_q;
      cap_clr    = '0;
      if (wr) begin
         case (address)
            ADDR_DATA:     data_out_d = wd;
            ADDR_IRQ_MASK: irq_mask_d = wd;
            ADDR_EDGE_CAP: cap_clr    = wd;
            ADDR_OUTSET:   data_out_d = data_out_q | wd;
            ADDR_OUTCLR:   data_out_d = data_out_q & ~wd;
            default:       ;
         endcase
      end
      edge_cap_d = (edge_cap_q & ~cap_clr) | edge_pulse;
   end

   // Register state
   always_ff @(posedge clk) begin
      if (reset) begin
         data_out_q <= RESET_VALUE;
         irq_mask_q <= '0;
         edge_cap_q <= '0;
      end else begin
         data_out_q <= data_out_d;
         irq_mask_q <= irq_mask_d;
         edge_cap_q <= edge_cap_d;
      end
   end

   // Zero-wait-state read mux, upper bits read as zero
   always_comb begin
      case (address)
         ADDR_DATA:     rd_w = in_s;
         ADDR_OUT:      rd_w = data_out_q;
         ADDR_IRQ_MASK: rd_w = irq_mask_q;
         ADDR_EDGE_CAP: rd_w = edge_cap_q;
         default:       rd_w = '0;
      endcase
      readdata             = '0;
      readdata[WIDTH-1:0]  = rd_w;
   end

   assign out_port = data_out_q;
   assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_avalon_gpio_pio.sv
module tb_avalon_gpio_pio;

`ifdef PIO_IN_SYNC_EN
   localparam int LAT = 2;
   localparam int ARM = 3;
`else
   localparam int LAT = 0;
   localparam int ARM = 1;
`endif

   localparam logic [31:0] WM [3] = '{32'h0000_3FFF, 32'hFFFF_FFFF, 32'h0000_0001};
   localparam logic [31:0] RV [3] = '{32'h0000_00A5, 32'h1234_5678, 32'h0000_0001};
   localparam int          ET [3] = '{0, 1, 2};

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] rd0, rd1, rd2;
   logic [13:0] in0, out0;
   logic [31:0] in1, out1;
   logic [0:0]  in2, out2;
   logic        irq0, irq1, irq2;

   int errors = 0;
   int checks = 0;

   // behavioural model state, 32-bit wide per instance, masked to width
   logic [31:0] m_out [3];
   logic [31:0] m_mask[3];
   logic [31:0] m_cap [3];
   logic [31:0] m_p0  [3];
   logic [31:0] m_p1  [3];
   logic [31:0] m_prev[3];
   int          m_since[3];

   avalon_gpio_pio #(.WIDTH(14), .RESET_VALUE(14'h0A5), .EDGE_TYPE(0)) dut0 (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd0),
      .in_port(in0), .out_port(out0), .irq(irq0));

   avalon_gpio_pio #(.WIDTH(32), .RESET_VALUE(32'h1234_5678), .EDGE_TYPE(1)) dut1 (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd1),
      .in_port(in1), .out_port(out1), .irq(irq1));

   avalon_gpio_pio #(.WIDTH(1), .RESET_VALUE(1'b1), .EDGE_TYPE(2)) dut2 (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd2),
      .in_port(in2), .out_port(out2), .irq(irq2));

   function automatic logic [31:0] get_in(int i);
      case (i)
         0:       return {18'h0, in0};
         1:       return in1;
         default: return {31'h0, in2};
      endcase
   endfunction

   function automatic logic [31:0] get_out(int i);
      case (i)
         0:       return {18'h0, out0};
         1:       return out1;
         default: return {31'h0, out2};
      endcase
   endfunction

   function automatic logic [31:0] get_rd(int i);
      case (i)
         0:       return rd0;
         1:       return rd1;
         default: return rd2;
      endcase
   endfunction

   function automatic logic get_irq(int i);
      case (i)
         0:       return irq0;
         1:       return irq1;
         default: return irq2;
      endcase
   endfunction

   // value the design currently sees as its sampled input
   function automatic logic [31:0] m_ins(int i);
      if (LAT != 0) return m_p1[i];
      return get_in(i) & WM[i];
   endfunction

   function automatic logic [31:0] m_read(int i, int a);
      case (a)
         0:       return m_ins(i);
         1:       return m_out[i];
         2:       return m_mask[i];
         3:       return m_cap[i];
         default: return 32'h0;
      endcase
   endfunction

   // advance the model by one clock using the inputs currently driven
   task automatic model_step();
      logic wr;
      wr = chipselect && !write_n;
      for (int i = 0; i < 3; i++) begin
         logic [31:0] s, ed, clr, wd;
         wd = writedata & WM[i];
         if (reset) begin
            m_out[i]   = RV[i];
            m_mask[i]  = 32'h0;
            m_cap[i]   = 32'h0;
            m_p0[i]    = 32'h0;
            m_p1[i]    = 32'h0;
            m_prev[i]  = 32'h0;
            m_since[i] = 0;
         end else begin
            s = m_ins(i);
            case (ET[i])
               0:       ed = s & ~m_prev[i];
               1:       ed = ~s & m_prev[i];
               default: ed = s ^ m_prev[i];
            endcase
            if (m_since[i] < ARM) ed = 32'h0;
            clr = (wr && address == 3'd3) ? wd : 32'h0;
            m_cap[i] = ((m_cap[i] & ~clr) | ed) & WM[i];
            if (wr) begin
               case (address)
                  3'd0:    m_out[i] = wd;
                  3'd2:    m_mask[i] = wd;
                  3'd4:    m_out[i] = m_out[i] | wd;
                  3'd5:    m_out[i] = m_out[i] & ~wd;
                  default: ;
               endcase
            end
            m_p1[i]   = m_p0[i];
            m_p0[i]   = get_in(i) & WM[i];
            m_prev[i] = s;
            if (m_since[i] < 100) m_since[i]++;
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("out_port[%0d]", i), get_out(i), m_out[i]);
         chk($sformatf("irq[%0d]", i), {31'h0, get_irq(i)}, {31'h0, |(m_cap[i] & m_mask[i])});
      end
   endtask

   // read-only access: change address with no write strobe, compare all DUTs
   task automatic rd_all(input int a);
      address = 3'(a);
      #1;
      for (int i = 0; i < 3; i++)
         chk($sformatf("rd[%0d]@%0d", i, a), get_rd(i), m_read(i, a));
   endtask

   task automatic wr_op(input int a, input logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = 3'(a);
      writedata  = d;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
      writedata = 32'h0;
      in0 = '1; in1 = '1; in2 = '1;
      repeat (3) tick();
      chk("reset out0", {18'h0, out0}, 32'h0A5);
      chk("reset irq0", {31'h0, irq0}, 32'h0);
      check_model();

      // inputs held high through reset release: no spurious captures
      reset = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("arm irq0", {31'h0, irq0}, 32'h0);
         check_model();
         rd_all(3);
         chk("arm cap0", rd0, 32'h0);
      end

      // output register: direct write, atomic clear and set
      wr_op(0, 32'h3FFF);
      chk("data out0", {18'h0, out0}, 32'h3FFF);
      wr_op(5, 32'h000F);
      chk("outclr out0", {18'h0, out0}, 32'h3FF0);
      wr_op(4, 32'h1000);
      chk("outset out0", {18'h0, out0}, 32'h3FF0);
      rd_all(1);
      chk("OUT rd0", rd0, 32'h3FF0);
      check_model();

      // rising edge on bit 0 with mask bit 0
      in0 = '0; in1 = '0; in2 = '0;
      repeat (4) tick();
      wr_op(3, 32'hFFFF_FFFF);
      wr_op(2, 32'h1);
      in0 = 14'h1;
      for (int k = 0; k < LAT; k++) begin
         tick();
         chk("pre-edge irq0", {31'h0, irq0}, 32'h0);
      end
      tick();
      chk("edge irq0", {31'h0, irq0}, 32'h1);
      rd_all(3);
      chk("edge cap0", rd0, 32'h1);
      wr_op(3, 32'h1);
      chk("w1c irq0", {31'h0, irq0}, 32'h0);
      check_model();

      // masked falling edge on bit 5 of the 32-bit falling-edge instance
      wr_op(2, 32'h0);
      in1 = 32'h20;
      repeat (LAT + 2) tick();
      wr_op(3, 32'hFFFF_FFFF);
      in1 = 32'h0;
      repeat (LAT + 1) tick();
      rd_all(3);
      chk("fall cap1", rd1, 32'h20);
      chk("fall masked irq1", {31'h0, irq1}, 32'h0);
      wr_op(2, 32'h20);
      chk("unmask irq1", {31'h0, irq1}, 32'h1);
      check_model();

      // set wins over same-cycle W1C on bit 3
      wr_op(3, 32'hFFFF_FFFF);
      in0 = 14'h9;
      repeat (LAT) tick();
      wr_op(3, 32'h8);
      rd_all(3);
      chk("set-wins cap0 bit3", rd0 & 32'h8, 32'h8);
      check_model();

      // upper bits and unmapped addresses read zero
      wr_op(2, 32'hFFFF_FFFF);
      rd_all(2);
      chk("mask rd0 width", rd0, 32'h3FFF);
      chk("mask rd1 width", rd1, 32'hFFFF_FFFF);
      chk("mask rd2 width", rd2, 32'h1);
      for (int a = 4; a < 8; a++) begin
         rd_all(a);
         chk("unmapped rd0", rd0, 32'h0);
      end

      // randomized traffic against the model
      for (int k = 0; k < 400; k++) begin
         int r;
         in0 = 14'($urandom);
         in1 = $urandom;
         in2 = 1'($urandom);
         r = $urandom_range(0, 9);
         reset = ($urandom_range(0, 63) == 0);
         if (r < 6) begin
            chipselect = 1'b1;
            write_n    = 1'b0;
            address    = 3'($urandom_range(0, 7));
            writedata  = $urandom;
         end else begin
            chipselect = ($urandom_range(0, 1) == 1);
            write_n    = 1'b1;
            address    = 3'($urandom_range(0, 7));
            writedata  = $urandom;
         end
         tick();
         reset      = 1'b0;
         chipselect = 1'b0;
         write_n    = 1'b1;
         check_model();
         rd_all($urandom_range(0, 7));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
